// File: rtl/imem_responder.sv
// Instruction-memory responder: answers CPU fetches from a preloadable word store
// after a programmable number of wait cycles, using a request/valid handshake.
module imem_responder #(
    parameter int          DEPTH    = 256,
    parameter int          LATENCY  = 1,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ireq,
    input  logic [31:0]              iaddr,
    output logic [31:0]              idata,
    output logic                     ivalid,
    output logic                     ierr,
    output logic                     busy,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_data
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] idata_reg;
    logic        ierr_reg;

    logic [31:0] mem [DEPTH];

    logic [31:0]   fetch_addr;
    logic [AW-1:0] fetch_idx;
    logic          fetch_good;
    logic [31:0]   fetch_word;
    logic          load_resp;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        case (state_reg)
            IDLE, RESP: begin
                state_next = IDLE;
                if (ireq) begin
                    addr_next  = iaddr;
                    cnt_next   = 3'(LATENCY);
                    state_next = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                // Leave at count 1 so the counter never wraps below zero.
                if (cnt_reg <= 3'd1) begin
                    cnt_next   = 3'd0;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // With zero latency the response is registered straight from the live request.
    assign fetch_addr = (state_reg == WAIT) ? addr_reg : iaddr;
    assign fetch_idx  = fetch_addr[AW+1:2];
    assign fetch_good = (fetch_addr[1:0] == 2'b00) && ((fetch_addr[31:2] >> AW) == 30'd0);
    assign fetch_word = (ld_en && (ld_addr == fetch_idx)) ? ld_data : mem[fetch_idx];
    assign load_resp  = (state_next == RESP);

    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
            addr_reg  <= 32'd0;
            idata_reg <= 32'd0;
            ierr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            ierr_reg  <= load_resp && !fetch_good;
            if (load_resp) begin
                idata_reg <= fetch_good ? fetch_word : NOP_WORD;
            end
        end
    end

    assign idata  = idata_reg;
    assign ierr   = ierr_reg;
    assign ivalid = (state_reg == RESP);
    assign busy   = (state_reg == WAIT);

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: three instances at LATENCY 1, 0 and 3
// share clock, reset and load port; each has its own request inputs.
module tb_imem_responder;
    logic        clk;
    logic        reset;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;

    logic        ireq1, ireq0, ireq3;
    logic [31:0] iaddr1, iaddr0, iaddr3;
    logic [31:0] idata1, idata0, idata3;
    logic        ivalid1, ivalid0, ivalid3;
    logic        ierr1, ierr0, ierr3;
    logic        busy1, busy0, busy3;

    int checks;
    int failures;

    logic [31:0] prog [4];

    imem_responder #(.DEPTH(256), .LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .ireq(ireq1), .iaddr(iaddr1), .idata(idata1),
        .ivalid(ivalid1), .ierr(ierr1), .busy(busy1),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

    imem_responder #(.DEPTH(256), .LATENCY(0)) u0 (
        .clk(clk), .reset(reset), .ireq(ireq0), .iaddr(iaddr0), .idata(idata0),
        .ivalid(ivalid0), .ierr(ierr0), .busy(busy0),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

    imem_responder #(.DEPTH(256), .LATENCY(3)) u3 (
        .clk(clk), .reset(reset), .ireq(ireq3), .iaddr(iaddr3), .idata(idata3),
        .ivalid(ivalid3), .ierr(ierr3), .busy(busy3),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response flags of one instance packed as {ivalid, ierr, busy}.
    task automatic chk_flags(input string tag, input logic v, input logic e, input logic b,
                             input logic [2:0] exp);
        chk(tag, {29'd0, v, e, b}, {29'd0, exp});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        prog[0]  = 32'h00500f93;
        prog[1]  = 32'h001f8f93;
        prog[2]  = 32'hffdff06f;
        prog[3]  = 32'h00000013;
        reset    = 1'b0;
        ld_en    = 1'b0;
        ld_addr  = 8'd0;
        ld_data  = 32'd0;
        ireq1 = 1'b0; ireq0 = 1'b0; ireq3 = 1'b0;
        iaddr1 = 32'd0; iaddr0 = 32'd0; iaddr3 = 32'd0;

        // Preload while in reset: memory writes are not gated by reset.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = 8'(i);
            ld_data = prog[i];
        end
        @(negedge clk);
        ld_en = 1'b0;
        chk("reset_idata", idata1, 32'd0);
        chk_flags("reset_flags", ivalid1, ierr1, busy1, 3'b000);
        reset = 1'b1;

        // LATENCY=1 single fetch of word 0.
        @(negedge clk);
        ireq1 = 1'b1; iaddr1 = 32'd0;
        @(negedge clk);
        ireq1 = 1'b0;
        chk_flags("l1_wait", ivalid1, ierr1, busy1, 3'b001);
        @(negedge clk);
        chk_flags("l1_resp", ivalid1, ierr1, busy1, 3'b100);
        chk("l1_data", idata1, 32'h00500f93);
        @(negedge clk);
        chk_flags("l1_after", ivalid1, ierr1, busy1, 3'b000);
        chk("l1_hold", idata1, 32'h00500f93);

        // LATENCY=0 back-to-back fetches under continuous ireq.
        ireq0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iaddr0 = 32'(i * 4);
            @(negedge clk);
            chk_flags($sformatf("l0_b2b_flags%0d", i), ivalid0, ierr0, busy0, 3'b100);
            chk($sformatf("l0_b2b_data%0d", i), idata0, prog[i]);
        end
        ireq0 = 1'b0;
        @(negedge clk);
        chk_flags("l0_idle", ivalid0, ierr0, busy0, 3'b000);

        // Misaligned fetch.
        ireq0 = 1'b1; iaddr0 = 32'h00000006;
        @(negedge clk);
        chk_flags("misalign_flags", ivalid0, ierr0, busy0, 3'b110);
        chk("misalign_data", idata0, 32'h00000013);
        // Good fetch clears ierr and moves idata away from the NOP word.
        iaddr0 = 32'h00000004;
        @(negedge clk);
        chk_flags("good_flags", ivalid0, ierr0, busy0, 3'b100);
        chk("good_data", idata0, 32'h001f8f93);
        // Out-of-range fetch (index 256).
        iaddr0 = 32'h00000400;
        @(negedge clk);
        chk_flags("range_flags", ivalid0, ierr0, busy0, 3'b110);
        chk("range_data", idata0, 32'h00000013);
        ireq0 = 1'b0;
        @(negedge clk);
        chk_flags("err_cleared", ivalid0, ierr0, busy0, 3'b000);
        chk("err_hold", idata0, 32'h00000013);

        // Write-first: load and fetch of word 3 on the same edge.
        ireq0 = 1'b1; iaddr0 = 32'd12;
        ld_en = 1'b1; ld_addr = 8'd3; ld_data = 32'h12345678;
        @(negedge clk);
        ireq0 = 1'b0; ld_en = 1'b0;
        chk_flags("wf_flags", ivalid0, ierr0, busy0, 3'b100);
        chk("wf_data", idata0, 32'h12345678);

        // LATENCY=3 with a load into the target word during WAIT.
        ireq3 = 1'b1; iaddr3 = 32'd8;
        @(negedge clk);
        ireq3 = 1'b0;
        ld_en = 1'b1; ld_addr = 8'd2; ld_data = 32'hdeadbeef;
        chk_flags("l3_c1", ivalid3, ierr3, busy3, 3'b001);
        @(negedge clk);
        ld_en = 1'b0;
        ireq3 = 1'b1; iaddr3 = 32'd0;
        chk_flags("l3_c2", ivalid3, ierr3, busy3, 3'b001);
        @(negedge clk);
        ireq3 = 1'b0;
        chk_flags("l3_c3", ivalid3, ierr3, busy3, 3'b001);
        @(negedge clk);
        chk_flags("l3_resp", ivalid3, ierr3, busy3, 3'b100);
        chk("l3_data", idata3, 32'hdeadbeef);
        @(negedge clk);
        chk_flags("l3_no_extra1", ivalid3, ierr3, busy3, 3'b000);
        @(negedge clk);
        chk_flags("l3_no_extra2", ivalid3, ierr3, busy3, 3'b000);

        // Reset during WAIT drops the pending response.
        ireq3 = 1'b1; iaddr3 = 32'd4;
        @(negedge clk);
        ireq3 = 1'b0;
        chk_flags("rst_pre", ivalid3, ierr3, busy3, 3'b001);
        reset = 1'b0;
        #1;
        chk_flags("rst_async", ivalid3, ierr3, busy3, 3'b000);
        chk("rst_async_data", idata3, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_flags($sformatf("rst_quiet%0d", i), ivalid3, ierr3, busy3, 3'b000);
            chk($sformatf("rst_quiet_data%0d", i), idata3, 32'd0);
        end

        // Memory survives reset.
        ireq3 = 1'b1; iaddr3 = 32'd0;
        @(negedge clk);
        ireq3 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_flags("post_rst_wait", ivalid3, ierr3, busy3, 3'b001);
        @(negedge clk);
        chk_flags("post_rst_resp", ivalid3, ierr3, busy3, 3'b100);
        chk("post_rst_data", idata3, 32'h00500f93);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
